// File: rtl/imem_pkg.sv
// Shared constants, phase encoding and address check for the instruction-memory controller.
// Pure declarations: no latency and no backpressure of its own.
package imem_pkg;

  localparam int DEPTH  = 64;
  localparam int AW     = $clog2(DEPTH);
  localparam int DATA_W = 32;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } phase_t;

  // A byte address is usable only if it is word aligned and lands inside the array.
  function automatic logic addr_ok(input logic [DATA_W-1:0] addr);
    return (addr[1:0] == 2'b00) && (addr[DATA_W-1:AW+2] == '0);
  endfunction

endpackage

// File: rtl/imem_access_ctrl_if.sv
// Fetch, loader and memory-array signals of the instruction-memory controller.
// The slave modport is the controller's view; master is the requester/memory side.
interface imem_access_ctrl_if;
  import imem_pkg::*;

  logic              f_req;
  logic [DATA_W-1:0] f_addr;
  logic              f_gnt;
  logic              f_valid;
  logic              f_err;
  logic [DATA_W-1:0] f_rdata;

  logic              l_req;
  logic              l_we;
  logic [DATA_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata;
  logic              l_done;
  logic              l_gnt;
  logic              l_valid;
  logic              l_err;
  logic [DATA_W-1:0] l_rdata;

  logic [AW-1:0]     mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, l_done, mem_rdata,
    output f_gnt, f_valid, f_err, f_rdata, l_gnt, l_valid, l_err, l_rdata,
           mem_addr, mem_we, mem_wdata
  );

  modport master (
    output f_req, f_addr, l_req, l_we, l_addr, l_wdata, l_done, mem_rdata,
    input  f_gnt, f_valid, f_err, f_rdata, l_gnt, l_valid, l_err, l_rdata,
           mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/imem_arb2.sv
// Two-way grant logic for the single memory port with a bounded fetch burst counter.
// Grants are combinational in the request cycle; the losing requester stalls by holding req.
module imem_arb2
  import imem_pkg::*;
#(
  parameter int FETCH_BURST = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic f_req,
  input  logic l_req,
  output logic f_gnt,
  output logic l_gnt
);

  localparam logic [3:0] BURST_MAX = 4'(FETCH_BURST);

  logic [3:0] burst_cnt;

  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (!rst) begin
      if (!run) begin
        l_gnt = l_req;
      end else if (f_req && (!l_req || (burst_cnt < BURST_MAX))) begin
        f_gnt = 1'b1;
      end else begin
        l_gnt = l_req;
      end
    end
  end

  // Counts fetch grants that the waiting loader has had to sit through.
  always_ff @(posedge clk) begin
    if (rst) begin
      burst_cnt <= 4'd0;
    end else if (!l_req || l_gnt) begin
      burst_cnt <= 4'd0;
    end else if (f_gnt && (burst_cnt < BURST_MAX)) begin
      burst_cnt <= burst_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/imem_access_ctrl.sv
// Shares one instruction-memory port between fetch and loader across BOOT/RUN; IMEM_ACCESS_STATS_EN adds grant counters.
// Grant and memory drive in the request cycle, response one cycle later; a losing requester stalls by holding req.
module imem_access_ctrl
  import imem_pkg::*;
#(
  parameter int FETCH_BURST = 4
) (
  input  logic                clk,
  input  logic                rst,
  imem_access_ctrl_if.slave   bus,
  output logic                running
`ifdef IMEM_ACCESS_STATS_EN
  ,
  output logic [15:0]         stat_fgnt,
  output logic [15:0]         stat_lgnt,
  output logic [15:0]         stat_conflict
`endif
);

  phase_t            state;
  logic              run_q;
  logic              f_gnt;
  logic              l_gnt;
  logic              f_ok;
  logic              l_ok;
  logic [AW-1:0]     addr_q;
  logic [AW-1:0]     addr_nxt;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] wdata_nxt;
  logic              f_vld_q;
  logic              f_err_q;
  logic              l_vld_q;
  logic              l_err_q;
  logic              l_rd_q;
  logic              f_valid;
  logic              l_valid;

  assign f_ok = addr_ok(bus.f_addr);
  assign l_ok = addr_ok(bus.l_addr);

  imem_arb2 #(
    .FETCH_BURST (FETCH_BURST)
  ) u_arb (
    .clk   (clk),
    .rst   (rst),
    .run   (state == RUN),
    .f_req (bus.f_req),
    .l_req (bus.l_req),
    .f_gnt (f_gnt),
    .l_gnt (l_gnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BOOT;
      run_q <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          if (bus.l_done) begin
            state <= RUN;
            run_q <= 1'b1;
          end
        end
        RUN:     run_q <= 1'b1;
        default: begin
          state <= BOOT;
          run_q <= 1'b0;
        end
      endcase
    end
  end

  // The port keeps its last address/data when idle so the array sees no spurious toggles.
  always_comb begin
    addr_nxt  = addr_q;
    wdata_nxt = wdata_q;
    if (f_gnt) begin
      addr_nxt = bus.f_addr[AW+1:2];
    end else if (l_gnt) begin
      addr_nxt  = bus.l_addr[AW+1:2];
      wdata_nxt = bus.l_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      f_vld_q <= 1'b0;
      f_err_q <= 1'b0;
      l_vld_q <= 1'b0;
      l_err_q <= 1'b0;
      l_rd_q  <= 1'b0;
    end else begin
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
      f_vld_q <= f_gnt;
      f_err_q <= f_gnt & ~f_ok;
      l_vld_q <= l_gnt;
      l_err_q <= l_gnt & ~l_ok;
      l_rd_q  <= l_gnt & ~bus.l_we & l_ok;
    end
  end

  // Responses are masked while rst is high so a grant just before reset never completes.
  assign f_valid       = f_vld_q & ~rst;
  assign l_valid       = l_vld_q & ~rst;
  assign running       = run_q & ~rst;

  assign bus.f_gnt     = f_gnt;
  assign bus.l_gnt     = l_gnt;
  assign bus.f_valid   = f_valid;
  assign bus.f_err     = f_err_q & ~rst;
  assign bus.f_rdata   = (f_valid && !f_err_q) ? bus.mem_rdata : '0;
  assign bus.l_valid   = l_valid;
  assign bus.l_err     = l_err_q & ~rst;
  assign bus.l_rdata   = (l_valid && l_rd_q) ? bus.mem_rdata : '0;

  assign bus.mem_addr  = rst ? '0 : addr_nxt;
  assign bus.mem_wdata = rst ? '0 : wdata_nxt;
  assign bus.mem_we    = l_gnt & bus.l_we & l_ok;

`ifdef IMEM_ACCESS_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_fgnt     <= '0;
      stat_lgnt     <= '0;
      stat_conflict <= '0;
    end else begin
      if (f_gnt && (stat_fgnt != 16'hFFFF)) stat_fgnt <= stat_fgnt + 16'd1;
      if (l_gnt && (stat_lgnt != 16'hFFFF)) stat_lgnt <= stat_lgnt + 16'd1;
      if ((state == RUN) && bus.f_req && bus.l_req && (stat_conflict != 16'hFFFF))
        stat_conflict <= stat_conflict + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imem_access_ctrl.sv
// Bench for imem_access_ctrl: directed BOOT/RUN scenarios plus randomized traffic against a word-array model.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_imem_access_ctrl;

  localparam int FB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic running;
  int   errors = 0;
  int   checks = 0;

  logic [31:0] tb_mem  [64] = '{default: 32'h0};
  logic [31:0] ref_mem [64] = '{default: 32'h0};
  logic [31:0] mem_q;

  imem_access_ctrl_if bus ();

`ifdef IMEM_ACCESS_STATS_EN
  logic [15:0] stat_fgnt, stat_lgnt, stat_conflict;
`endif

  imem_access_ctrl #(
    .FETCH_BURST (FB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .running       (running)
`ifdef IMEM_ACCESS_STATS_EN
    ,
    .stat_fgnt     (stat_fgnt),
    .stat_lgnt     (stat_lgnt),
    .stat_conflict (stat_conflict)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous write-first memory array.
  always @(posedge clk) begin
    if (bus.mem_we) tb_mem[bus.mem_addr] <= bus.mem_wdata;
    mem_q <= bus.mem_we ? bus.mem_wdata : tb_mem[bus.mem_addr];
  end
  assign bus.mem_rdata = mem_q;

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  function automatic logic good_addr(input logic [31:0] a);
    return (a % 4 == 0) && (a < 256);
  endfunction

  function automatic logic [31:0] rand_addr();
    int          r;
    logic [31:0] w;
    r = $urandom_range(0, 9);
    w = 32'($urandom_range(0, 7)) * 4;
    if (r == 0) return w + 32'($urandom_range(1, 3));
    if (r == 1) return w | (32'h100 << $urandom_range(0, 23));
    return w;
  endfunction

  task automatic test_reset();
    bus.f_req = 1'b1; bus.f_addr = 32'h24;
    bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_addr = 32'h24; bus.l_wdata = 32'h02114820;
    bus.l_done = 1'b0;
    drive_edge();
    drive_edge();
    @(negedge clk);
    checks++; if (bus.f_gnt !== 1'b0) begin errors++; $display("FAIL rst_fgnt got=%b exp=0", bus.f_gnt); end
    checks++; if (bus.l_gnt !== 1'b0) begin errors++; $display("FAIL rst_lgnt got=%b exp=0", bus.l_gnt); end
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got=%b exp=0", bus.mem_we); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL rst_running got=%b exp=0", running); end
    checks++; if ({bus.f_valid, bus.f_err, bus.l_valid, bus.l_err} !== 4'b0) begin
      errors++; $display("FAIL rst_resp got=%b exp=0000", {bus.f_valid, bus.f_err, bus.l_valid, bus.l_err}); end
    checks++; if ({bus.f_rdata, bus.l_rdata, bus.mem_wdata} !== 96'h0) begin
      errors++; $display("FAIL rst_data got=%h/%h/%h exp=0", bus.f_rdata, bus.l_rdata, bus.mem_wdata); end
    checks++; if (bus.mem_addr !== 6'd0) begin errors++; $display("FAIL rst_mem_addr got=%0d exp=0", bus.mem_addr); end
  endtask

  task automatic test_boot_write();
    drive_edge();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.l_gnt !== 1'b1) begin errors++; $display("FAIL boot_lgnt got=%b exp=1", bus.l_gnt); end
    checks++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL boot_mem_we got=%b exp=1", bus.mem_we); end
    checks++; if (bus.mem_addr !== 6'd9) begin errors++; $display("FAIL boot_mem_addr got=%0d exp=9", bus.mem_addr); end
    checks++; if (bus.f_gnt !== 1'b0) begin errors++; $display("FAIL boot_fgnt got=%b exp=0", bus.f_gnt); end
    ref_mem[9] = 32'h02114820;
    drive_edge();
    bus.l_req = 1'b0; bus.l_we = 1'b0;
    @(negedge clk);
    checks++; if ({bus.l_valid, bus.l_err} !== 2'b10) begin
      errors++; $display("FAIL boot_lresp got=%b exp=10", {bus.l_valid, bus.l_err}); end
    checks++; if (bus.l_rdata !== 32'h0) begin errors++; $display("FAIL boot_lrdata got=%h exp=0", bus.l_rdata); end
    checks++; if (bus.f_gnt !== 1'b0) begin errors++; $display("FAIL boot_fgnt2 got=%b exp=0", bus.f_gnt); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL boot_running got=%b exp=0", running); end
  endtask

  task automatic test_run_fetch();
    drive_edge();
    bus.l_done = 1'b1;
    @(negedge clk);
    checks++; if (bus.f_gnt !== 1'b0) begin errors++; $display("FAIL done_fgnt got=%b exp=0", bus.f_gnt); end
    drive_edge();
    bus.l_done = 1'b0;
    @(negedge clk);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL run_running got=%b exp=1", running); end
    checks++; if (bus.f_gnt !== 1'b1) begin errors++; $display("FAIL run_fgnt got=%b exp=1", bus.f_gnt); end
    drive_edge();
    bus.f_req = 1'b0;
    @(negedge clk);
    checks++; if ({bus.f_valid, bus.f_err} !== 2'b10) begin
      errors++; $display("FAIL run_fresp got=%b exp=10", {bus.f_valid, bus.f_err}); end
    checks++; if (bus.f_rdata !== 32'h02114820) begin
      errors++; $display("FAIL run_frdata got=%h exp=02114820", bus.f_rdata); end
  endtask

  task automatic test_burst();
    bit exp_f [12] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1};
    drive_edge();
    bus.f_req = 1'b1; bus.f_addr = 32'h24;
    bus.l_req = 1'b1; bus.l_we = 1'b0; bus.l_addr = 32'h0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.f_gnt, bus.l_gnt} !== {exp_f[i], ~exp_f[i]}) begin
        errors++; $display("FAIL burst_%0d got f/l=%b%b exp=%b%b", i, bus.f_gnt, bus.l_gnt, exp_f[i], ~exp_f[i]);
      end
      drive_edge();
    end
    bus.f_req = 1'b0; bus.l_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_bad_addr();
    drive_edge();
    bus.f_req = 1'b1; bus.f_addr = 32'h26;
    bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_addr = 32'h100; bus.l_wdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if ({bus.f_gnt, bus.l_gnt, bus.mem_we} !== 3'b100) begin
      errors++; $display("FAIL bad_c1 got f/l/we=%b exp=100", {bus.f_gnt, bus.l_gnt, bus.mem_we}); end
    drive_edge();
    bus.f_req = 1'b0;
    @(negedge clk);
    checks++; if ({bus.f_valid, bus.f_err} !== 2'b11) begin
      errors++; $display("FAIL bad_fresp got=%b exp=11", {bus.f_valid, bus.f_err}); end
    checks++; if (bus.f_rdata !== 32'h0) begin errors++; $display("FAIL bad_frdata got=%h exp=0", bus.f_rdata); end
    checks++; if ({bus.l_gnt, bus.mem_we} !== 2'b10) begin
      errors++; $display("FAIL bad_lgnt got l/we=%b exp=10", {bus.l_gnt, bus.mem_we}); end
    drive_edge();
    bus.l_req = 1'b0; bus.l_we = 1'b0;
    @(negedge clk);
    checks++; if ({bus.l_valid, bus.l_err} !== 2'b11) begin
      errors++; $display("FAIL bad_lresp got=%b exp=11", {bus.l_valid, bus.l_err}); end
    checks++; if (bus.l_rdata !== 32'h0) begin errors++; $display("FAIL bad_lrdata got=%h exp=0", bus.l_rdata); end
    checks++; if (tb_mem[0] !== ref_mem[0] || tb_mem[9] !== ref_mem[9]) begin
      errors++; $display("FAIL bad_mem got=%h/%h exp=%h/%h", tb_mem[0], tb_mem[9], ref_mem[0], ref_mem[9]); end
  endtask

  task automatic test_back_to_back();
    drive_edge();
    bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_addr = 32'h0; bus.l_wdata = 32'h20110012;
    @(negedge clk);
    checks++; if ({bus.l_gnt, bus.mem_we} !== 2'b11) begin
      errors++; $display("FAIL b2b_wr got l/we=%b exp=11", {bus.l_gnt, bus.mem_we}); end
    ref_mem[0] = 32'h20110012;
    drive_edge();
    bus.l_req = 1'b0; bus.l_we = 1'b0;
    bus.f_req = 1'b1; bus.f_addr = 32'h0;
    @(negedge clk);
    checks++; if ({bus.f_gnt, bus.l_valid} !== 2'b11) begin
      errors++; $display("FAIL b2b_rd got fgnt/lvalid=%b exp=11", {bus.f_gnt, bus.l_valid}); end
    drive_edge();
    bus.f_req = 1'b0;
    @(negedge clk);
    checks++; if (bus.f_valid !== 1'b1 || bus.f_rdata !== 32'h20110012) begin
      errors++; $display("FAIL b2b_data got v=%b d=%h exp v=1 d=20110012", bus.f_valid, bus.f_rdata); end
  endtask

  task automatic test_random();
    logic        pf, pl, lwe, xf, xl, xwe;
    logic [31:0] fa, la, lwd, efd, eld;
    logic        efv, efe, elv, ele;
    int          waited;
    pf = 0; pl = 0; lwe = 0; fa = 0; la = 0; lwd = 0;
    efv = 0; efe = 0; elv = 0; ele = 0; efd = 0; eld = 0; waited = 0;
    for (int c = 0; c < 400; c++) begin
      drive_edge();
      if (!pf && $urandom_range(0, 2) != 0) begin pf = 1; fa = rand_addr(); end
      if (!pl && $urandom_range(0, 2) == 0) begin
        pl = 1; lwe = 1'($urandom_range(0, 1)); la = rand_addr(); lwd = $urandom;
      end
      bus.f_req = pf; bus.f_addr = fa;
      bus.l_req = pl; bus.l_we = lwe; bus.l_addr = la; bus.l_wdata = lwd;
      bus.l_done = ($urandom_range(0, 15) == 0);
      @(negedge clk);
      // Fetch wins unless the loader has already waited through FB fetch grants.
      xf = pf && (!pl || waited < FB);
      xl = pl && !xf;
      xwe = xl && lwe && good_addr(la);
      checks++; if ({bus.f_gnt, bus.l_gnt, bus.mem_we} !== {xf, xl, xwe}) begin
        errors++; $display("FAIL rnd_gnt c=%0d got f/l/we=%b exp=%b", c, {bus.f_gnt, bus.l_gnt, bus.mem_we}, {xf, xl, xwe}); end
      checks++; if (running !== 1'b1) begin errors++; $display("FAIL rnd_running c=%0d got=%b exp=1", c, running); end
      checks++; if ({bus.f_valid, bus.f_err, bus.f_rdata} !== {efv, efe, efd}) begin
        errors++; $display("FAIL rnd_fresp c=%0d got=%b%b %h exp=%b%b %h", c, bus.f_valid, bus.f_err, bus.f_rdata, efv, efe, efd); end
      checks++; if ({bus.l_valid, bus.l_err, bus.l_rdata} !== {elv, ele, eld}) begin
        errors++; $display("FAIL rnd_lresp c=%0d got=%b%b %h exp=%b%b %h", c, bus.l_valid, bus.l_err, bus.l_rdata, elv, ele, eld); end
      efv = xf; efe = xf && !good_addr(fa);
      efd = (xf && good_addr(fa)) ? ref_mem[fa[7:2]] : 32'h0;
      elv = xl; ele = xl && !good_addr(la);
      eld = (xl && !lwe && good_addr(la)) ? ref_mem[la[7:2]] : 32'h0;
      if (xwe) ref_mem[la[7:2]] = lwd;
      if (!pl || xl) waited = 0;
      else if (xf && waited < FB) waited++;
      if (xf) pf = 0;
      if (xl) pl = 0;
    end
    drive_edge();
    bus.f_req = 1'b0; bus.l_req = 1'b0; bus.l_we = 1'b0; bus.l_done = 1'b0;
    @(negedge clk);
    checks++; if ({bus.f_valid, bus.f_err, bus.f_rdata, bus.l_valid, bus.l_err, bus.l_rdata} !== {efv, efe, efd, elv, ele, eld}) begin
      errors++; $display("FAIL rnd_drain got=%b%b %h %b%b %h", bus.f_valid, bus.f_err, bus.f_rdata, bus.l_valid, bus.l_err, bus.l_rdata); end
  endtask

  task automatic test_reset_inflight();
    drive_edge();
    bus.f_req = 1'b1; bus.f_addr = 32'h24;
    @(negedge clk);
    checks++; if (bus.f_gnt !== 1'b1) begin errors++; $display("FAIL rsti_fgnt got=%b exp=1", bus.f_gnt); end
    drive_edge();
    bus.f_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({bus.f_valid, bus.l_valid, bus.f_err, running, bus.mem_we} !== 5'b0) begin
      errors++; $display("FAIL rsti_outs got=%b exp=00000", {bus.f_valid, bus.l_valid, bus.f_err, running, bus.mem_we}); end
    checks++; if ({bus.f_rdata, bus.mem_addr} !== 38'h0) begin
      errors++; $display("FAIL rsti_data got=%h/%0d exp=0", bus.f_rdata, bus.mem_addr); end
    drive_edge();
    rst = 1'b0;
    bus.f_req = 1'b1;
    @(negedge clk);
    checks++; if ({running, bus.f_gnt, bus.f_valid} !== 3'b000) begin
      errors++; $display("FAIL rsti_boot got run/fgnt/fv=%b exp=000", {running, bus.f_gnt, bus.f_valid}); end
    drive_edge();
    bus.f_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_boot_write();
    test_run_fetch();
    test_burst();
    test_bad_addr();
    test_back_to_back();
    test_random();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_access_ctrl.md
Name: imem_access_ctrl

Overview:
- Controller for the single-port, 64-word instruction memory. It shares that memory between two requesters: the CPU fetch path (read-only) and the program loader (read/write, used for boot and debug).
- Sequences a BOOT phase, in which only the loader is served, followed by a RUN phase, in which fetch has bounded priority over the loader.
- Converts byte addresses to word indices and rejects bad addresses.
- Sits between the fetch stage, the loader, and the instruction-memory array.

Parameters:
- DEPTH, 64, number of 32-bit words in the instruction memory.
- AW, 6, word-index width; must equal clog2(DEPTH).
- FETCH_BURST, 4, maximum consecutive fetch grants while the loader is waiting; legal range 1..15.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- f_req  in  1  fetch read request.
- f_addr  in  32  fetch byte address.
- f_gnt  out  1  fetch request accepted this cycle.
- f_valid  out  1  fetch response valid; occurs 1 cycle after f_gnt.
- f_err  out  1  qualifies f_valid: bad address, f_rdata is 0.
- f_rdata  out  32  fetched instruction.
- l_req  in  1  loader request.
- l_we  in  1  1 = write, 0 = read.
- l_addr  in  32  loader byte address.
- l_wdata  in  32  loader write data.
- l_done  in  1  single-cycle pulse: boot load complete.
- l_gnt  out  1  loader request accepted this cycle.
- l_valid  out  1  loader response valid; occurs 1 cycle after l_gnt (for reads and writes).
- l_err  out  1  qualifies l_valid: bad address.
- l_rdata  out  32  loader read data; 0 for writes and errors.
- running  out  1  1 in the RUN phase.
- mem_addr  out  AW  word index = addr[AW+1:2].
- mem_we  out  1  write strobe.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  memory read data; synchronous, valid the cycle after mem_addr is presented.

Behaviour:
- Reset: state=BOOT, burst counter=0, every output 0. An in-flight response is discarded; no f_valid or l_valid is produced for a request granted in the cycle before reset.
- At most one grant per cycle. Grant and memory drive happen in the same cycle (gnt is combinational from req and state). The response is registered, 1-cycle latency. Fully pipelined: a new grant is allowed every cycle.
- Requester rules:
  - A requester holds req, addr and data stable until it sees gnt.
  - gnt is never asserted without req.
- Bad address: addr[1:0]!=0 or addr[31:AW+2]!=0.
  - Still granted; mem_we is forced to 0.
  - Next cycle: valid=1, err=1, rdata=0.
- FSM:
  - BOOT: only the loader is granted; f_gnt=0. l_done moves the state to RUN on the next edge. A loader grant in the same cycle as l_done completes normally.
  - RUN:
    - Only f_req: grant fetch.
    - Only l_req: grant loader.
    - Both: grant fetch while burst count < FETCH_BURST, else grant loader.
  - RUN is left only by rst. l_done in RUN is ignored.
- Burst counter:
  - Increments on a fetch grant while l_req=1.
  - Clears on any loader grant, or on any cycle with l_req=0.
  - Saturates at FETCH_BURST.
- mem_we = l_gnt & l_we & address OK.
- mem_addr/mem_wdata are driven from the granted requester. With no grant, they hold their last value and mem_we=0.
- A write followed by a read of the same word on the next cycle returns the new data, because the memory is write-first.
- running = (state==RUN).

Optional Feature:
- IMEM_ACCESS_STATS_EN.
- Defined: adds three 16-bit saturating counters as outputs `stat_fgnt`, `stat_lgnt`, `stat_conflict`.
  - `stat_fgnt`: fetch grants.
  - `stat_lgnt`: loader grants.
  - `stat_conflict`: cycles with f_req&l_req in RUN.
  - All three clear on rst.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package `imem_pkg`:
  - Constants DEPTH=64, AW=6, DATA_W=32.
  - Phase encoding: BOOT=1'b0, RUN=1'b1.
  - Function `addr_ok(addr)`.
- Sub-module `imem_arb2`: combinational fixed-priority/burst grant logic plus the burst counter.
- The top level holds the FSM, memory muxing and response registers.

Test Plan:
- BOOT write, then reset release with l_req, l_we=1, l_addr=0x24, l_wdata=0x02114820 -> l_gnt same cycle, mem_we=1, mem_addr=9, then l_valid=1, l_err=0. f_req held 1 throughout BOOT -> f_gnt stays 0.
- l_done pulse, then f_req with f_addr=0x24 -> running=1 next cycle; f_gnt; next cycle f_valid=1, f_rdata=0x02114820.
- RUN, f_req and l_req both held for 12 cycles, FETCH_BURST=4 -> grant pattern F,F,F,F,L,F,F,F,F,L,F,F.
- f_addr=0x26 (misaligned) and l_addr=0x100 write (out of range) -> f_err=1 with f_rdata=0; l_err=1; mem_we never 1; memory contents unchanged.
- Pipelined back-to-back: loader writes 0x20110012 to word 0, fetch reads word 0 in the next cycle -> f_rdata=0x20110012.
- rst asserted in the cycle after a fetch grant -> no f_valid; state=BOOT; running=0; all outputs 0.
